// File: rtl/multi_cycle_ctrl.sv
// Purpose : sequencing FSM for the multi-cycle MIPS-subset datapath (fetch/decode/execute/mem/wb).
// Latency : control outputs are combinational from the current state; CPI 3..5 with zero-wait memory.
// Backpress: FETCH/MEM_RD/MEM_WR hold until mem_ready; STALL_LIMIT idle cycles abort to FETCH and set mem_err.
//
// Ports:
//   clk_100Mhz, rst_n       clock, async active-low reset
//   op, funct, zero         instruction fields from IR, ALU zero flag
//   mem_ready               memory finishes the current access this cycle
//   pc_write..pc_source     datapath strobes and mux selects
//   state                   current state code (debug)
//   instr_done, illegal     one-cycle retire / unsupported-instruction pulses
//   mem_err, instr_cnt      sticky timeout flag, retired-instruction counter
module multi_cycle_ctrl #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic        clk_100Mhz,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_err,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXE    = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_I_EXE    = 4'd11,
    S_I_WB     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  // Last stall-count value before the wait is declared a timeout.
  localparam logic [7:0] STALL_LAST = 8'(STALL_LIMIT - 1);

  state_t      state_q, state_d;
  logic [7:0]  stall_cnt;
  logic [31:0] cnt_q;
  logic        mem_err_q;
  logic        stall_wait;
  logic        timeout;
  logic        funct_ok;

  assign state     = state_q;
  assign instr_cnt = cnt_q;
  assign mem_err   = mem_err_q;

  assign stall_wait = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  // A ready in the limit cycle wins: the access completes normally.
  assign timeout    = stall_wait && !mem_ready && (stall_cnt == STALL_LAST);

  assign funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                    (funct == 6'h25) || (funct == 6'h2A);

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      stall_cnt <= 8'd0;
      cnt_q     <= 32'd0;
      mem_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // A timeout in FETCH re-enters FETCH, so it must clear the count explicitly.
      if (!stall_wait || timeout || (state_d != state_q)) begin
        stall_cnt <= 8'd0;
      end else if (!mem_ready) begin
        stall_cnt <= stall_cnt + 8'd1;
      end
      if (timeout) begin
        mem_err_q <= 1'b1;
      end
      if (instr_done) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculative branch target: PC + (imm << 2).
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE: begin
            if (funct_ok) begin
              state_d = S_R_EXE;
            end else begin
              illegal = 1'b1;
              state_d = S_FETCH;
            end
          end
          OP_BEQ:  state_d = S_BRANCH;
          OP_J:    state_d = S_JUMP;
          OP_ADDI: state_d = S_I_EXE;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_R_EXE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b01;
        pc_source  = 2'b01;
        pc_write   = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_I_EXE: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_I_WB;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Abandon the access outright: no side effects from the timed-out instruction.
    if (timeout) begin
      state_d    = S_FETCH;
      pc_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule
